prio_event_arbiter: RTL and testbench

Parametrised, registered event arbiter for N request channels. Captures rising edges on `req_i` into a sticky pending vector and selects one pending channel per grant, by fixed priority (highest index wins) or round-robin. Presents the grant as an index on a valid/ready output port. Sits between raw pushbutton/sensor request lines and the downstream consumer of channel codes, replacing the combinational 16-input priority encoder.

---
 rtl/prio_event_arbiter.sv | 132 +++++++++++++
 tb/tb_prio_event_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/prio_event_arbiter.sv
// Registered event arbiter: turns rising edges on N request lines into sticky
// pending bits and grants one per accept, by fixed priority or round-robin.
module prio_event_arbiter #(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             mode_i,
    input  logic             clr_ovf_i,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_multi,
    output logic [N-1:0]     pend_o,
    output logic             overflow_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     req_q, req_d;
    logic [N-1:0]     pend_q, pend_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             multi_q, multi_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [N-1:0]     accMask;
    logic [N-1:0]     riseVec;
    logic [N-1:0]     candVec;
    logic             selFound;
    logic [IDX_W-1:0] selIdx;
    logic             selMulti;
    int               searchStart;
    int               searchPos;

    // Edge detect, accept mask and the candidate set seen by the selector.
    always_comb begin
        accept  = (state_q == HOLD) && out_ready;
        accMask = '0;
        if (accept) begin
            accMask[idx_q] = 1'b1;
        end
        riseVec  = req_i & ~req_q;
        candVec  = pend_q & ~accMask;
        selMulti = |(candVec & (candVec - N'(1)));
    end

    // Descending search from start-1 with wrap; fixed priority is the
    // same walk starting from 0, so both modes share one loop.
    always_comb begin
        selFound    = 1'b0;
        selIdx      = '0;
        searchPos   = 0;
        searchStart = mode_i ? int'(last_q) : 0;
        for (int off = 1; off <= N; off++) begin
            searchPos = searchStart - off;
            if (searchPos < 0) begin
                searchPos = searchPos + N;
            end
            if (!selFound && candVec[searchPos[IDX_W-1:0]]) begin
                selFound = 1'b1;
                selIdx   = searchPos[IDX_W-1:0];
            end
        end
    end

    // Next-state for the output stage plus pending/overflow bookkeeping.
    always_comb begin
        state_d = state_q;
        req_d   = req_i;
        pend_d  = candVec | riseVec;
        last_d  = last_q;
        idx_d   = idx_q;
        multi_d = multi_q;
        ovf_d   = ovf_q;

        if (|(riseVec & candVec)) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end

        if (accept) begin
            last_d = idx_q;
        end

        // A held grant only moves on accept; an empty stage loads whenever it can.
        if (state_q == EMPTY || accept) begin
            if (selFound) begin
                idx_d   = selIdx;
                multi_d = selMulti;
                state_d = HOLD;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            req_q   <= '0;
            pend_q  <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            multi_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            multi_q <= multi_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign out_idx    = idx_q;
    assign out_multi  = multi_q;
    assign pend_o     = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_prio_event_arbiter.sv
// Directed bench for prio_event_arbiter (N=16): a cycle-by-cycle vector table
// plus hand-written reset sequences with hand-computed expectations.
module tb_prio_event_arbiter;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_i;
    logic             mode_i;
    logic             clr_ovf_i;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_multi;
    logic [N-1:0]     pend_o;
    logic             overflow_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string            tag;
        logic             rst;
        logic             mode;
        logic             ready;
        logic             clr;
        logic [N-1:0]     req;
        logic             expValid;
        logic [IDX_W-1:0] expIdx;
        logic             expMulti;
        logic [N-1:0]     expPend;
        logic             expOvf;
    } vec_t;

    vec_t vecs[$];

    prio_event_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .mode_i     (mode_i),
        .clr_ovf_i  (clr_ovf_i),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_multi  (out_multi),
        .pend_o     (pend_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string tag, input logic r, input logic m,
                                input logic rdy, input logic c, input logic [N-1:0] rq,
                                input logic v, input int idx, input logic mu,
                                input logic [N-1:0] p, input logic o);
        vec_t t;
        t.tag = tag; t.rst = r; t.mode = m; t.ready = rdy; t.clr = c; t.req = rq;
        t.expValid = v; t.expIdx = IDX_W'(idx); t.expMulti = mu; t.expPend = p; t.expOvf = o;
        return t;
    endfunction

    task automatic applyStimulus(input logic r, input logic m, input logic rdy,
                                 input logic c, input logic [N-1:0] rq);
        rst = r; mode_i = m; out_ready = rdy; clr_ovf_i = c; req_i = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string field, input logic [63:0] got,
                       input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, field, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [IDX_W-1:0] idx,
                               input logic mu, input logic [N-1:0] p, input logic o);
        cmp(tag, "valid", 64'(out_valid), 64'(v));
        cmp(tag, "idx",   64'(out_idx),   64'(idx));
        cmp(tag, "multi", 64'(out_multi), 64'(mu));
        cmp(tag, "pend",  64'(pend_o),    64'(p));
        cmp(tag, "ovf",   64'(overflow_o), 64'(o));
    endtask

    initial begin
        rst = 1'b1; mode_i = 1'b0; out_ready = 1'b0; clr_ovf_i = 1'b0; req_i = '0;

        // Reset with random requests, then release with channel 7 held high.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, N'($urandom));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, N'($urandom));
        checkOutput("reset", 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0080);
        checkOutput("rel_e1", 1'b0, 4'd0, 1'b0, 16'h0080, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0080);
        checkOutput("rel_e2", 1'b1, 4'd7, 1'b0, 16'h0080, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("rel_acc", 1'b0, 4'd7, 1'b0, 16'h0000, 1'b0);

        // Fixed priority: 3 and 12 together.
        vecs.push_back(mk("fp_rise",  0,0,1,0,16'h1008, 0, 7,0,16'h1008,0));
        vecs.push_back(mk("fp_g12",   0,0,1,0,16'h0000, 1,12,1,16'h1008,0));
        vecs.push_back(mk("fp_g3",    0,0,1,0,16'h0000, 1, 3,0,16'h0008,0));
        vecs.push_back(mk("fp_empty", 0,0,1,0,16'h0000, 0, 3,0,16'h0000,0));
        // Backpressure: 5 held for 5 cycles while 15 arrives.
        vecs.push_back(mk("bp_rise5", 0,0,0,0,16'h0020, 0, 3,0,16'h0020,0));
        vecs.push_back(mk("bp_g5",    0,0,0,0,16'h0000, 1, 5,0,16'h0020,0));
        vecs.push_back(mk("bp_r15",   0,0,0,0,16'h8000, 1, 5,0,16'h8020,0));
        vecs.push_back(mk("bp_hold3", 0,0,0,0,16'h0000, 1, 5,0,16'h8020,0));
        vecs.push_back(mk("bp_hold4", 0,0,0,0,16'h0000, 1, 5,0,16'h8020,0));
        vecs.push_back(mk("bp_hold5", 0,0,0,0,16'h0000, 1, 5,0,16'h8020,0));
        vecs.push_back(mk("bp_g15",   0,0,1,0,16'h0000, 1,15,0,16'h8000,0));
        vecs.push_back(mk("bp_empty", 0,0,1,0,16'h0000, 0,15,0,16'h0000,0));
        // Overflow: channel 4 pulsed twice while held.
        vecs.push_back(mk("ov_rise",  0,0,0,0,16'h0010, 0,15,0,16'h0010,0));
        vecs.push_back(mk("ov_g4",    0,0,0,0,16'h0000, 1, 4,0,16'h0010,0));
        vecs.push_back(mk("ov_again", 0,0,0,0,16'h0010, 1, 4,0,16'h0010,1));
        vecs.push_back(mk("ov_hold",  0,0,0,0,16'h0000, 1, 4,0,16'h0010,1));
        vecs.push_back(mk("ov_acc",   0,0,1,0,16'h0000, 0, 4,0,16'h0000,1));
        vecs.push_back(mk("ov_clr",   0,0,0,1,16'h0000, 0, 4,0,16'h0000,0));
        // Rise on the channel being accepted in the same edge.
        vecs.push_back(mk("sa_rise",  0,0,0,0,16'h0010, 0, 4,0,16'h0010,0));
        vecs.push_back(mk("sa_g4",    0,0,0,0,16'h0000, 1, 4,0,16'h0010,0));
        vecs.push_back(mk("sa_accr",  0,0,1,0,16'h0010, 0, 4,0,16'h0010,0));
        vecs.push_back(mk("sa_reg4",  0,0,0,0,16'h0000, 1, 4,0,16'h0010,0));
        vecs.push_back(mk("sa_done",  0,0,1,0,16'h0000, 0, 4,0,16'h0000,0));
        // Round-robin from a fresh reset: {2,5,9} then {5,12} with last=9.
        vecs.push_back(mk("rr_rst",   1,1,0,0,16'h0000, 0, 0,0,16'h0000,0));
        vecs.push_back(mk("rr_rise",  0,1,0,0,16'h0224, 0, 0,0,16'h0224,0));
        vecs.push_back(mk("rr_g9",    0,1,0,0,16'h0000, 1, 9,1,16'h0224,0));
        vecs.push_back(mk("rr_g5",    0,1,1,0,16'h0000, 1, 5,1,16'h0024,0));
        vecs.push_back(mk("rr_g2",    0,1,1,0,16'h0000, 1, 2,0,16'h0004,0));
        vecs.push_back(mk("rr_empty", 0,1,1,0,16'h0000, 0, 2,0,16'h0000,0));
        vecs.push_back(mk("rr_r9",    0,1,0,0,16'h0200, 0, 2,0,16'h0200,0));
        vecs.push_back(mk("rr_l9",    0,1,0,0,16'h0000, 1, 9,0,16'h0200,0));
        vecs.push_back(mk("rr_r5_12", 0,1,1,0,16'h1020, 0, 9,0,16'h1020,0));
        vecs.push_back(mk("rr_g5b",   0,1,0,0,16'h0000, 1, 5,1,16'h1020,0));
        vecs.push_back(mk("rr_g12",   0,1,1,0,16'h0000, 1,12,0,16'h1000,0));
        vecs.push_back(mk("rr_end",   0,1,1,0,16'h0000, 0,12,0,16'h0000,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].mode, vecs[i].ready, vecs[i].clr, vecs[i].req);
            checkOutput(vecs[i].tag, vecs[i].expValid, vecs[i].expIdx, vecs[i].expMulti,
                        vecs[i].expPend, vecs[i].expOvf);
        end

        // Mid-operation reset while a grant is being accepted (last was 12).
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0012);
        checkOutput("mr_rise", 1'b0, 4'd12, 1'b0, 16'h0012, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("mr_g4", 1'b1, 4'd4, 1'b1, 16'h0012, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("mr_rst", 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0);
        // With last cleared, {3,13} must yield 13; a stale last of 4 or 12 yields 3.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h2008);
        checkOutput("mr_rise2", 1'b0, 4'd0, 1'b0, 16'h2008, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("mr_g13", 1'b1, 4'd13, 1'b1, 16'h2008, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("mr_g3", 1'b1, 4'd3, 1'b0, 16'h0008, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
